// File: rtl/wbu_pkg.sv
// Shared definitions for the write-back/commit stage: CSR addresses,
// mstatus/mie/mip bit positions, the timer-interrupt cause and FSM states.
package wbu_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIP_MTIP     = 7;

    localparam logic [31:0] MCAUSE_MTI    = 32'h8000_0007;
    localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;

    typedef enum logic {
        RUN,
        SHADOW
    } wbu_state_e;

endpackage

// File: rtl/wbu_csr_counter.sv
// Wide CSR counter with an increment enable and independent low/high half
// write ports. A write to either half takes precedence over the increment.
module wbu_csr_counter #(
    parameter int W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_en,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [W/2-1:0]   wdata,
    output logic [W-1:0]     count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: half writes replace their half, otherwise optional increment.
    always_comb begin
        count_d = count_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) count_d[W/2-1:0] = wdata;
            if (wr_hi) count_d[W-1:W/2] = wdata;
        end else if (inc_en) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/wbu_trap_csr.sv
// Write-back/commit stage: GPR write-back, machine-mode CSR file, trap entry,
// mret, cycle/instret counters and a one-cycle flush-shadow FSM.
// Optional timer interrupts are enabled by defining WBU_INTR_EN.
module wbu_trap_csr
    import wbu_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              CNT_W       = 64,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0,
    parameter logic [XLEN-1:0] HARTID      = '0,
    parameter logic [XLEN-1:0] MARCHID     = XLEN'(32'h015fdeeb)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_gpr_waddr,
    input  logic [XLEN-1:0] in_gpr_wdata,
    input  logic            in_csr_wen,
    input  logic [11:0]     in_csr_waddr,
    input  logic [XLEN-1:0] in_csr_wdata,
    input  logic            in_exc,
    input  logic [XLEN-1:0] in_cause,
    input  logic [XLEN-1:0] in_tval,
    input  logic            in_ret,
    input  logic            in_fencei,
    output logic            gpr_wen,
    output logic [4:0]      gpr_waddr,
    output logic [XLEN-1:0] gpr_wdata,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] csr_rdata,
    output logic            cs_flush,
    output logic [XLEN-1:0] cs_dnpc,
    output logic            fencei
`ifdef WBU_INTR_EN
    ,
    input  logic            irq_timer
`endif
);

    wbu_state_e      state_q, state_d;
    logic [XLEN-1:0] dnpc_q, dnpc_d;
    logic            fencei_flag_q, fencei_flag_d;
    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
`ifdef WBU_INTR_EN
    logic            mie_mtie_q, mie_mtie_d;
`endif

    logic             acc;
    logic             irq_taken;
    logic             trap;
    logic             csr_we;
    logic [CNT_W-1:0] mcycle;
    logic [CNT_W-1:0] minstret;
    logic [XLEN-1:0]  mstatus_rd;

    assign acc = in_valid && (state_q == RUN);

`ifdef WBU_INTR_EN
    assign irq_taken = acc & mstatus_mie_q & mie_mtie_q & irq_timer & ~in_exc;
`else
    assign irq_taken = 1'b0;
`endif

    assign trap   = acc & (in_exc | irq_taken);
    assign csr_we = acc & in_csr_wen & ~trap;

    assign in_ready  = 1'b1;
    assign gpr_wen   = acc & ~in_exc & ~irq_taken & (in_gpr_waddr != 5'd0);
    assign gpr_waddr = in_gpr_waddr;
    assign gpr_wdata = in_gpr_wdata;

    assign cs_flush = (state_q == SHADOW);
    assign fencei   = (state_q == SHADOW) & fencei_flag_q;
    assign cs_dnpc  = dnpc_q;

    // Flush FSM and redirect target; targets use pre-update CSR values.
    always_comb begin
        state_d       = RUN;
        dnpc_d        = dnpc_q;
        fencei_flag_d = 1'b0;
        if (acc) begin
            if (in_csr_wen | in_exc | in_ret | in_fencei | irq_taken) state_d = SHADOW;
            if (trap)        dnpc_d = {mtvec_q[XLEN-1:2], 2'b00};
            else if (in_ret) dnpc_d = mepc_q;
            else             dnpc_d = in_pc + XLEN'(4);
            fencei_flag_d = in_fencei & ~trap;
        end
    end

    // CSR updates: software write first, then trap entry or mret override.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
`ifdef WBU_INTR_EN
        mie_mtie_d     = mie_mtie_q;
`endif
        if (csr_we) begin
            case (in_csr_waddr)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = in_csr_wdata[MSTATUS_MIE];
                    mstatus_mpie_d = in_csr_wdata[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_d    = in_csr_wdata;
                CSR_MSCRATCH: mscratch_d = in_csr_wdata;
                CSR_MEPC:     mepc_d     = in_csr_wdata;
                CSR_MCAUSE:   mcause_d   = in_csr_wdata;
                CSR_MTVAL:    mtval_d    = in_csr_wdata;
`ifdef WBU_INTR_EN
                CSR_MIE:      mie_mtie_d = in_csr_wdata[MIE_MTIE];
`endif
                default: ;
            endcase
        end
        if (trap) begin
            mepc_d         = in_pc;
            mcause_d       = irq_taken ? XLEN'(MCAUSE_MTI) : in_cause;
            mtval_d        = irq_taken ? '0 : in_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (acc && in_ret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    // State, redirect and CSR registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= RUN;
            dnpc_q         <= '0;
            fencei_flag_q  <= 1'b0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mtvec_q        <= RESET_MTVEC;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
`ifdef WBU_INTR_EN
            mie_mtie_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            dnpc_q         <= dnpc_d;
            fencei_flag_q  <= fencei_flag_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
`ifdef WBU_INTR_EN
            mie_mtie_q     <= mie_mtie_d;
`endif
        end
    end

    wbu_csr_counter #(.W(CNT_W)) u_mcycle (
        .clock  (clock),
        .reset  (reset),
        .inc_en (1'b1),
        .wr_lo  (csr_we && (in_csr_waddr == CSR_MCYCLE)),
        .wr_hi  (csr_we && (in_csr_waddr == CSR_MCYCLEH)),
        .wdata  (in_csr_wdata[CNT_W/2-1:0]),
        .count  (mcycle)
    );

    wbu_csr_counter #(.W(CNT_W)) u_minstret (
        .clock  (clock),
        .reset  (reset),
        .inc_en (acc & ~trap),
        .wr_lo  (csr_we && (in_csr_waddr == CSR_MINSTRET)),
        .wr_hi  (csr_we && (in_csr_waddr == CSR_MINSTRETH)),
        .wdata  (in_csr_wdata[CNT_W/2-1:0]),
        .count  (minstret)
    );

    // mstatus view with MPP hardwired to machine mode.
    always_comb begin
        mstatus_rd               = '0;
        mstatus_rd[12:11]        = 2'b11;
        mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
        mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
    end

    // Combinational CSR read port returning pre-write values.
    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_MSTATUS:   csr_rdata = mstatus_rd;
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MTVAL:     csr_rdata = mtval_q;
`ifdef WBU_INTR_EN
            CSR_MIE:       csr_rdata[MIE_MTIE] = mie_mtie_q;
            CSR_MIP:       csr_rdata[MIP_MTIP] = irq_timer;
`endif
            CSR_MCYCLE:    csr_rdata = XLEN'(mcycle[CNT_W/2-1:0]);
            CSR_MCYCLEH:   csr_rdata = XLEN'(mcycle[CNT_W-1:CNT_W/2]);
            CSR_MINSTRET:  csr_rdata = XLEN'(minstret[CNT_W/2-1:0]);
            CSR_MINSTRETH: csr_rdata = XLEN'(minstret[CNT_W-1:CNT_W/2]);
            CSR_MVENDORID: csr_rdata = XLEN'(MVENDORID_VAL);
            CSR_MARCHID:   csr_rdata = MARCHID;
            CSR_MHARTID:   csr_rdata = HARTID;
            default:       csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_wbu_trap_csr.sv
// Directed bench for wbu_trap_csr. Inputs change on the falling edge,
// combinational outputs are sampled shortly after, registered outputs are
// sampled on the following falling edge.
module tb_wbu_trap_csr;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_gpr_waddr;
    logic [31:0] in_gpr_wdata;
    logic        in_csr_wen;
    logic [11:0] in_csr_waddr;
    logic [31:0] in_csr_wdata;
    logic        in_exc;
    logic [31:0] in_cause;
    logic [31:0] in_tval;
    logic        in_ret;
    logic        in_fencei;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        cs_flush;
    logic [31:0] cs_dnpc;
    logic        fencei;
`ifdef WBU_INTR_EN
    logic        irq_timer;
`endif

    int checks = 0;
    int errors = 0;
    int exp_instret = 0;
    logic [31:0] rd;

    wbu_trap_csr dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_gpr_waddr (in_gpr_waddr),
        .in_gpr_wdata (in_gpr_wdata),
        .in_csr_wen   (in_csr_wen),
        .in_csr_waddr (in_csr_waddr),
        .in_csr_wdata (in_csr_wdata),
        .in_exc       (in_exc),
        .in_cause     (in_cause),
        .in_tval      (in_tval),
        .in_ret       (in_ret),
        .in_fencei    (in_fencei),
        .gpr_wen      (gpr_wen),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata),
        .cs_flush     (cs_flush),
        .cs_dnpc      (cs_dnpc),
        .fencei       (fencei)
`ifdef WBU_INTR_EN
        ,
        .irq_timer    (irq_timer)
`endif
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic clear_inputs;
        in_valid     = 1'b0;
        in_pc        = '0;
        in_gpr_waddr = '0;
        in_gpr_wdata = '0;
        in_csr_wen   = 1'b0;
        in_csr_waddr = '0;
        in_csr_wdata = '0;
        in_exc       = 1'b0;
        in_cause     = '0;
        in_tval      = '0;
        in_ret       = 1'b0;
        in_fencei    = 1'b0;
        csr_raddr    = '0;
`ifdef WBU_INTR_EN
        irq_timer    = 1'b0;
`endif
    endtask

    task automatic step;
        @(negedge clock);
    endtask

    task automatic read_csr(input logic [11:0] a, output logic [31:0] v);
        csr_raddr = a;
        #1;
        v = csr_rdata;
    endtask

    // Issue a csrw, sit out the shadow cycle, return in RUN.
    task automatic csr_write(input logic [11:0] a, input logic [31:0] d, input logic [31:0] pc);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_csr_wen   = 1'b1;
        in_csr_waddr = a;
        in_csr_wdata = d;
        step;
        clear_inputs;
        step;
    endtask

    task automatic test_reset;
        clear_inputs;
        reset = 1'b1;
        repeat (3) step;
        reset = 1'b0;
        exp_instret = 0;
        #1;
        checks++; if (cs_flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_cs_flush: got %0h want 0", cs_flush); end
        checks++; if (fencei !== 1'b0) begin errors++; $display("[TB] FAIL reset_fencei: got %0h want 0", fencei); end
        checks++; if (cs_dnpc !== 32'h0) begin errors++; $display("[TB] FAIL reset_dnpc: got %h want 0", cs_dnpc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0h want 1", in_ready); end
        read_csr(12'h300, rd);
        checks++; if (rd !== 32'h1800) begin errors++; $display("[TB] FAIL reset_mstatus: got %h want 00001800", rd); end
        read_csr(12'h305, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_mtvec: got %h want 0", rd); end
        read_csr(12'hB02, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_minstret: got %h want 0", rd); end
        read_csr(12'hF11, rd);
        checks++; if (rd !== 32'h79737978) begin errors++; $display("[TB] FAIL mvendorid: got %h want 79737978", rd); end
        read_csr(12'hF12, rd);
        checks++; if (rd !== 32'h015fdeeb) begin errors++; $display("[TB] FAIL marchid: got %h want 015fdeeb", rd); end
        read_csr(12'hF14, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mhartid: got %h want 0", rd); end
        step;
    endtask

    task automatic test_addi;
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_gpr_waddr = 5'd5; in_gpr_wdata = 32'd7;
        read_csr(12'hB02, rd);
        checks++; if (gpr_wen !== 1'b1) begin errors++; $display("[TB] FAIL addi_gpr_wen: got %0h want 1", gpr_wen); end
        checks++; if (gpr_waddr !== 5'd5) begin errors++; $display("[TB] FAIL addi_waddr: got %0d want 5", gpr_waddr); end
        checks++; if (gpr_wdata !== 32'd7) begin errors++; $display("[TB] FAIL addi_wdata: got %0d want 7", gpr_wdata); end
        checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL addi_minstret_pre: got %0d want 0", rd); end
        step; clear_inputs; exp_instret++;
        read_csr(12'hB02, rd);
        checks++; if (cs_flush !== 1'b0) begin errors++; $display("[TB] FAIL addi_no_flush: got %0h want 0", cs_flush); end
        checks++; if (rd !== 32'(exp_instret)) begin errors++; $display("[TB] FAIL addi_minstret: got %0d want %0d", rd, exp_instret); end
        // write to x0 commits but never writes the register file
        in_valid = 1'b1; in_pc = 32'h8000_0004; in_gpr_waddr = 5'd0; in_gpr_wdata = 32'd3;
        #1;
        checks++; if (gpr_wen !== 1'b0) begin errors++; $display("[TB] FAIL x0_gpr_wen: got %0h want 0", gpr_wen); end
        step; clear_inputs; exp_instret++;
        read_csr(12'hB02, rd);
        checks++; if (rd !== 32'(exp_instret)) begin errors++; $display("[TB] FAIL x0_minstret: got %0d want %0d", rd, exp_instret); end
    endtask

    task automatic test_csr_flush;
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_csr_wen = 1'b1;
        in_csr_waddr = 12'h305; in_csr_wdata = 32'h8000_0100;
        read_csr(12'h305, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL csrw_pre_read: got %h want 0", rd); end
        checks++; if (cs_flush !== 1'b0) begin errors++; $display("[TB] FAIL csrw_flush_early: got %0h want 0", cs_flush); end
        step; exp_instret++;
        // wrong-path instruction arrives during the shadow cycle
        in_valid = 1'b1; in_pc = 32'h8000_0004; in_gpr_waddr = 5'd7; in_gpr_wdata = 32'h55;
        in_csr_wen = 1'b1; in_csr_waddr = 12'h340; in_csr_wdata = 32'h99;
        read_csr(12'h305, rd);
        checks++; if (cs_flush !== 1'b1) begin errors++; $display("[TB] FAIL csrw_flush: got %0h want 1", cs_flush); end
        checks++; if (cs_dnpc !== 32'h8000_0004) begin errors++; $display("[TB] FAIL csrw_dnpc: got %h want 80000004", cs_dnpc); end
        checks++; if (gpr_wen !== 1'b0) begin errors++; $display("[TB] FAIL shadow_gpr_wen: got %0h want 0", gpr_wen); end
        checks++; if (fencei !== 1'b0) begin errors++; $display("[TB] FAIL csrw_fencei: got %0h want 0", fencei); end
        checks++; if (rd !== 32'h8000_0100) begin errors++; $display("[TB] FAIL csrw_mtvec: got %h want 80000100", rd); end
        step; clear_inputs;
        read_csr(12'hB02, rd);
        checks++; if (cs_flush !== 1'b0) begin errors++; $display("[TB] FAIL flush_one_cycle: got %0h want 0", cs_flush); end
        checks++; if (rd !== 32'(exp_instret)) begin errors++; $display("[TB] FAIL shadow_minstret: got %0d want %0d", rd, exp_instret); end
        read_csr(12'h340, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL shadow_csr_write: got %h want 0", rd); end
    endtask

    task automatic test_ecall_mret;
        csr_write(12'h300, 32'h8, 32'h8000_0008); exp_instret++;
        read_csr(12'h300, rd);
        checks++; if (rd !== 32'h1808) begin errors++; $display("[TB] FAIL set_mie: got %h want 00001808", rd); end
        in_valid = 1'b1; in_exc = 1'b1; in_cause = 32'd11; in_pc = 32'h8000_0010;
        in_gpr_waddr = 5'd3; in_gpr_wdata = 32'd1;
        #1;
        checks++; if (gpr_wen !== 1'b0) begin errors++; $display("[TB] FAIL ecall_gpr_wen: got %0h want 0", gpr_wen); end
        step; clear_inputs;
        checks++; if (cs_flush !== 1'b1) begin errors++; $display("[TB] FAIL ecall_flush: got %0h want 1", cs_flush); end
        checks++; if (cs_dnpc !== 32'h8000_0100) begin errors++; $display("[TB] FAIL ecall_dnpc: got %h want 80000100", cs_dnpc); end
        read_csr(12'h341, rd);
        checks++; if (rd !== 32'h8000_0010) begin errors++; $display("[TB] FAIL ecall_mepc: got %h want 80000010", rd); end
        read_csr(12'h342, rd);
        checks++; if (rd !== 32'd11) begin errors++; $display("[TB] FAIL ecall_mcause: got %h want 0000000b", rd); end
        read_csr(12'h300, rd);
        checks++; if (rd !== 32'h1880) begin errors++; $display("[TB] FAIL ecall_mstatus: got %h want 00001880", rd); end
        read_csr(12'hB02, rd);
        checks++; if (rd !== 32'(exp_instret)) begin errors++; $display("[TB] FAIL ecall_minstret: got %0d want %0d", rd, exp_instret); end
        step;
        in_valid = 1'b1; in_ret = 1'b1; in_pc = 32'h8000_0100;
        step; clear_inputs; exp_instret++;
        checks++; if (cs_flush !== 1'b1) begin errors++; $display("[TB] FAIL mret_flush: got %0h want 1", cs_flush); end
        checks++; if (cs_dnpc !== 32'h8000_0010) begin errors++; $display("[TB] FAIL mret_dnpc: got %h want 80000010", cs_dnpc); end
        read_csr(12'h300, rd);
        checks++; if (rd !== 32'h1888) begin errors++; $display("[TB] FAIL mret_mstatus: got %h want 00001888", rd); end
        read_csr(12'hB02, rd);
        checks++; if (rd !== 32'(exp_instret)) begin errors++; $display("[TB] FAIL mret_minstret: got %0d want %0d", rd, exp_instret); end
        step;
    endtask

    task automatic test_exc_csr_conflict;
        csr_write(12'h340, 32'h1111_1111, 32'h8000_0030); exp_instret++;
        in_valid = 1'b1; in_exc = 1'b1; in_cause = 32'd2; in_tval = 32'h0000_abcd; in_pc = 32'h8000_0040;
        in_csr_wen = 1'b1; in_csr_waddr = 12'h340; in_csr_wdata = 32'hdead_beef;
        step; clear_inputs;
        checks++; if (cs_flush !== 1'b1) begin errors++; $display("[TB] FAIL conflict_flush: got %0h want 1", cs_flush); end
        checks++; if (cs_dnpc !== 32'h8000_0100) begin errors++; $display("[TB] FAIL conflict_dnpc: got %h want 80000100", cs_dnpc); end
        read_csr(12'h340, rd);
        checks++; if (rd !== 32'h1111_1111) begin errors++; $display("[TB] FAIL conflict_mscratch: got %h want 11111111", rd); end
        read_csr(12'h342, rd);
        checks++; if (rd !== 32'd2) begin errors++; $display("[TB] FAIL conflict_mcause: got %h want 00000002", rd); end
        read_csr(12'h343, rd);
        checks++; if (rd !== 32'h0000_abcd) begin errors++; $display("[TB] FAIL conflict_mtval: got %h want 0000abcd", rd); end
        read_csr(12'h341, rd);
        checks++; if (rd !== 32'h8000_0040) begin errors++; $display("[TB] FAIL conflict_mepc: got %h want 80000040", rd); end
        read_csr(12'h300, rd);
        checks++; if (rd !== 32'h1880) begin errors++; $display("[TB] FAIL conflict_mstatus: got %h want 00001880", rd); end
        step;
    endtask

    task automatic test_fencei;
        in_valid = 1'b1; in_fencei = 1'b1; in_pc = 32'h8000_0050;
        step; clear_inputs; exp_instret++;
        checks++; if (cs_flush !== 1'b1) begin errors++; $display("[TB] FAIL fencei_flush: got %0h want 1", cs_flush); end
        checks++; if (fencei !== 1'b1) begin errors++; $display("[TB] FAIL fencei_pulse: got %0h want 1", fencei); end
        checks++; if (cs_dnpc !== 32'h8000_0054) begin errors++; $display("[TB] FAIL fencei_dnpc: got %h want 80000054", cs_dnpc); end
        step;
        checks++; if (fencei !== 1'b0) begin errors++; $display("[TB] FAIL fencei_end: got %0h want 0", fencei); end
    endtask

    task automatic test_back_to_back;
        in_valid = 1'b1; in_pc = 32'h8000_0060; in_gpr_waddr = 5'd8; in_gpr_wdata = 32'd1;
        #1;
        checks++; if (gpr_wen !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_wen: got %0h want 1", gpr_wen); end
        step; exp_instret++;
        in_pc = 32'h8000_0064; in_gpr_waddr = 5'd9; in_gpr_wdata = 32'd2;
        #1;
        checks++; if (gpr_wen !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_wen: got %0h want 1", gpr_wen); end
        checks++; if (gpr_waddr !== 5'd9) begin errors++; $display("[TB] FAIL b2b_waddr: got %0d want 9", gpr_waddr); end
        checks++; if (cs_flush !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flush: got %0h want 0", cs_flush); end
        step; clear_inputs; exp_instret++;
        read_csr(12'hB02, rd);
        checks++; if (rd !== 32'(exp_instret)) begin errors++; $display("[TB] FAIL b2b_minstret: got %0d want %0d", rd, exp_instret); end
    endtask

    task automatic test_counters;
        csr_write(12'hB80, 32'h0, 32'h8000_0070); exp_instret++;
        in_valid = 1'b1; in_pc = 32'h8000_0074; in_csr_wen = 1'b1;
        in_csr_waddr = 12'hB00; in_csr_wdata = 32'hFFFF_FFFF;
        step; clear_inputs; exp_instret++;
        read_csr(12'hB00, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mcycle_written: got %h want ffffffff", rd); end
        read_csr(12'hB80, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mcycleh_before: got %h want 0", rd); end
        step;
        read_csr(12'hB00, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mcycle_wrap_lo: got %h want 0", rd); end
        read_csr(12'hB80, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("[TB] FAIL mcycle_wrap_hi: got %h want 1", rd); end
        // writing minstreth suppresses the increment of that csrw
        csr_write(12'hB82, 32'h5, 32'h8000_0078);
        read_csr(12'hB82, rd);
        checks++; if (rd !== 32'h5) begin errors++; $display("[TB] FAIL minstreth_write: got %h want 5", rd); end
        read_csr(12'hB02, rd);
        checks++; if (rd !== 32'(exp_instret)) begin errors++; $display("[TB] FAIL minstret_suppress: got %0d want %0d", rd, exp_instret); end
    endtask

    task automatic test_unmapped;
        csr_write(12'h7C0, 32'hCAFE_F00D, 32'h8000_0080); exp_instret++;
        read_csr(12'h7C0, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got %h want 0", rd); end
`ifndef WBU_INTR_EN
        csr_write(12'h304, 32'h80, 32'h8000_0084); exp_instret++;
        read_csr(12'h304, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mie_absent: got %h want 0", rd); end
        read_csr(12'h344, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mip_absent: got %h want 0", rd); end
`endif
    endtask

    task automatic test_reset_in_shadow;
        in_valid = 1'b1; in_pc = 32'h8000_0090; in_csr_wen = 1'b1;
        in_csr_waddr = 12'h340; in_csr_wdata = 32'h77;
        step; clear_inputs;
        checks++; if (cs_flush !== 1'b1) begin errors++; $display("[TB] FAIL rs_flush_before: got %0h want 1", cs_flush); end
        reset = 1'b1;
        step;
        read_csr(12'h340, rd);
        checks++; if (cs_flush !== 1'b0) begin errors++; $display("[TB] FAIL rs_flush_in_reset: got %0h want 0", cs_flush); end
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rs_mscratch: got %h want 0", rd); end
        reset = 1'b0; exp_instret = 0;
        step;
        read_csr(12'hB02, rd);
        checks++; if (cs_flush !== 1'b0) begin errors++; $display("[TB] FAIL rs_flush_after: got %0h want 0", cs_flush); end
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rs_minstret: got %0d want 0", rd); end
    endtask

`ifdef WBU_INTR_EN
    task automatic test_timer_irq;
        csr_write(12'h305, 32'h8000_0100, 32'h8000_0000); exp_instret++;
        csr_write(12'h300, 32'h8, 32'h8000_0004); exp_instret++;
        csr_write(12'h304, 32'h80, 32'h8000_0008); exp_instret++;
        read_csr(12'h344, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL mip_idle: got %h want 0", rd); end
        irq_timer = 1'b1;
        read_csr(12'h344, rd);
        checks++; if (rd !== 32'h80) begin errors++; $display("[TB] FAIL mip_mtip: got %h want 80", rd); end
        read_csr(12'h304, rd);
        checks++; if (rd !== 32'h80) begin errors++; $display("[TB] FAIL mie_mtie: got %h want 80", rd); end
        in_valid = 1'b1; in_pc = 32'h8000_0020; in_gpr_waddr = 5'd6; in_gpr_wdata = 32'd9;
        #1;
        checks++; if (gpr_wen !== 1'b0) begin errors++; $display("[TB] FAIL irq_gpr_wen: got %0h want 0", gpr_wen); end
        step; clear_inputs;
        checks++; if (cs_flush !== 1'b1) begin errors++; $display("[TB] FAIL irq_flush: got %0h want 1", cs_flush); end
        checks++; if (cs_dnpc !== 32'h8000_0100) begin errors++; $display("[TB] FAIL irq_dnpc: got %h want 80000100", cs_dnpc); end
        read_csr(12'h342, rd);
        checks++; if (rd !== 32'h8000_0007) begin errors++; $display("[TB] FAIL irq_mcause: got %h want 80000007", rd); end
        read_csr(12'h341, rd);
        checks++; if (rd !== 32'h8000_0020) begin errors++; $display("[TB] FAIL irq_mepc: got %h want 80000020", rd); end
        read_csr(12'h343, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL irq_mtval: got %h want 0", rd); end
        read_csr(12'h300, rd);
        checks++; if (rd !== 32'h1880) begin errors++; $display("[TB] FAIL irq_mstatus: got %h want 00001880", rd); end
        read_csr(12'hB02, rd);
        checks++; if (rd !== 32'(exp_instret)) begin errors++; $display("[TB] FAIL irq_minstret: got %0d want %0d", rd, exp_instret); end
        step;
    endtask
`endif

    initial begin
        reset = 1'b1;
        clear_inputs;
        test_reset;
        test_addi;
        test_csr_flush;
        test_ecall_mret;
        test_exc_csr_conflict;
        test_fencei;
        test_back_to_back;
        test_counters;
        test_unmapped;
        test_reset_in_shadow;
`ifdef WBU_INTR_EN
        test_timer_irq;
`endif
        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wbu_trap_csr.md
Name: wbu_trap_csr

Overview:
- Parametrised write-back/commit stage: the last pipeline stage after EXU.
- Drives GPR write-back, owns the machine-mode CSR file (trap state, 64-bit cycle/instret counters) and raises a registered one-cycle flush to the control-state unit with the redirect PC.
- Adds over the previous WBU: real mcause/mtval, mstatus MIE/MPIE stacking, counters, a flush-shadow FSM that discards wrong-path commits, and optional timer interrupts.

Parameters:
- XLEN, 32, datapath/CSR width.
- CNT_W, 64, mcycle/minstret width; only 64 is supported, giving low/high CSR halves.
- RESET_MTVEC, 32'h0, mtvec value after reset.
- HARTID, 0, value returned by mhartid.
- MARCHID, 32'h015fdeeb, value returned by marchid.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  EXU result valid
- in_ready  out  1  constant 1
- in_pc  in  XLEN  PC of the instruction
- in_gpr_waddr  in  5  destination register
- in_gpr_wdata  in  XLEN  write-back data
- in_csr_wen  in  1  CSR write request
- in_csr_waddr  in  12  CSR address
- in_csr_wdata  in  XLEN  CSR write data
- in_exc  in  1  synchronous exception (ecall etc.)
- in_cause  in  XLEN  exception code
- in_tval  in  XLEN  trap value
- in_ret  in  1  mret
- in_fencei  in  1  fence.i
- gpr_wen  out  1  GPR write enable
- gpr_waddr  out  5  GPR write address
- gpr_wdata  out  XLEN  GPR write data
- csr_raddr  in  12  CSR read address
- csr_rdata  out  XLEN  CSR read data
- cs_flush  out  1  one-cycle flush pulse
- cs_dnpc  out  XLEN  redirect target, registered
- fencei  out  1  one-cycle fence.i pulse
- irq_timer  in  1  machine timer interrupt level; exists only under WBU_INTR_EN

Behaviour:
- Accept condition: acc = in_valid & state==RUN. Inputs are ignored when acc=0.
- FSM with two states, RUN and SHADOW; reset state is RUN.
  - RUN→SHADOW when acc and the instruction is flush-causing: in_csr_wen | in_exc | in_ret | in_fencei | interrupt taken.
  - SHADOW→RUN unconditionally after 1 cycle.
  - In SHADOW, in_valid is wrong-path: no GPR write, no CSR update, minstret is not incremented.
- Flush outputs:
  - cs_flush = state==SHADOW.
  - fencei = SHADOW & registered fencei flag.
  - cs_dnpc is registered on acc with priority interrupt/exc → {mtvec[XLEN-1:2],2'b00}, then ret → mepc, else in_pc+4.
  - Both target operands use pre-update CSR values.
- GPR write: gpr_wen = acc & ~in_exc & ~irq_taken & (in_gpr_waddr!=0). Address and data pass through combinationally.
- CSR read: csr_rdata is combinational and returns the pre-write value. A same-cycle write becomes visible the next cycle.
- CSR map:
  - mstatus 0x300, with MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11.
  - mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - mvendorid 0xF11 = 32'h79737978, marchid 0xF12 = MARCHID, mhartid 0xF14 = HARTID.
  - Unmapped addresses read 0; writes to them are ignored.
- Trap entry on acc & in_exc:
  - mepc←in_pc, mcause←in_cause, mtval←in_tval.
  - MPIE←MIE, MIE←0.
  - A simultaneous in_csr_wen is dropped; the exception wins.
- mret on acc & in_ret & ~in_exc: MIE←MPIE, MPIE←1.
- in_exc & in_ret together denotes ebreak and is treated as an exception; the sim halt hook stays outside this spec.
- Counters:
  - mcycle increments every cycle, including SHADOW; it wraps at 2^64 to 0.
  - minstret increments on each acc with no trap.
  - A CSR write to any counter half replaces that half and suppresses that counter's increment in the same cycle.
- Reset values:
  - mstatus=32'h1800, mtvec=RESET_MTVEC; all other CSRs and counters 0.
  - cs_flush=0, fencei=0, cs_dnpc=0.
  - Reset during SHADOW returns the FSM to RUN with no flush pulse.

Optional Feature:
- Macro WBU_INTR_EN.
- Defined:
  - irq_timer port exists; mip.MTIP (bit7) = irq_timer; mie.MTIE (bit7) is writable.
  - If acc & MIE & MTIE & irq_timer & ~in_exc, the incoming instruction is not committed (no GPR/CSR write, no minstret).
  - Trap entry then runs with mepc←in_pc, mcause←32'h80000007, mtval←0, followed by the flush.
- Undefined: port absent; mie/mip read 0, writes ignored; no interrupts.

Decomposition:
- Shared package wbu_pkg holds:
  - the CSR address localparams;
  - the mstatus bit-index constants;
  - MCAUSE_MTI;
  - the FSM state enum.
- One natural sub-module, wbu_csr_counter: a 64-bit counter with increment enable and low/high write ports, instantiated twice.

Test Plan:
- Reset, then addi x5 (acc, waddr 5, wdata 7) → gpr_wen=1, cs_flush stays 0, minstret=1 next cycle.
- csrw mtvec=0x80000100 at pc 0x80000000 → cs_flush pulses once the next cycle with cs_dnpc=0x80000004. An in_valid during SHADOW yields gpr_wen=0 and no minstret increment.
- ecall (in_exc, cause 11, pc 0x80000010, MIE=1) → mepc=0x80000010, mcause=11, MIE=0, MPIE=1, cs_dnpc=0x80000100. A following mret → cs_dnpc=0x80000010, MIE=1.
- in_exc with in_csr_wen to mscratch in the same cycle → mscratch unchanged, trap taken.
- Write mcycle=32'hFFFFFFFF with mcycleh=0 → after 1 cycle mcycleh=1, mcycle=0.
- WBU_INTR_EN: MIE=1, MTIE=1, irq_timer=1 on a valid addi x6 at pc 0x80000020 → no GPR write, mcause=0x80000007, mepc=0x80000020, flush issued.
